// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: accepts one access at a time and answers after LATENCY cycles.
// Optional DMEM_BYTE_WRITE_EN macro enables per-lane store masking via req_be.
module dmem_resp #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_M
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit ZERO_LAT = (LATENCY == 0);
    localparam int LAT_M1_I = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0] LAT_M1 = LAT_M1_I[3:0];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle strobe, resp_rdata/resp_err hold until the next response.
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, access;

    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    logic        acc_we, acc_err;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_be;
    logic [AW-1:0] acc_idx;
    logic [31:0] old_word, wr_word;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    assign accept = req_valid && (state_q == IDLE);
    assign access = (accept && ZERO_LAT) || ((state_q == WAIT) && (cnt_q == 4'd0));

    // With zero latency the access happens on the accept edge, so it uses the live request.
    assign acc_we    = (state_q == IDLE) ? req_we    : cap_we;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : cap_wdata;
    assign acc_be    = (state_q == IDLE) ? req_be    : cap_be;

    assign acc_idx  = acc_addr[AW+1:2];
    assign acc_err  = (|acc_addr[1:0]) || (|acc_addr[31:AW+2]);
    assign old_word = mem[acc_idx];

`ifdef DMEM_BYTE_WRITE_EN
    always_comb begin
        wr_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
        end
    end
`else
    logic unused_be;
    assign unused_be = ^acc_be;
    assign wr_word   = acc_wdata;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ZERO_LAT) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end
            if (access) begin
                err_q   <= acc_err;
                rdata_q <= acc_err ? 32'd0 : old_word;
            end
        end
    end

    // Storage is deliberately not reset; a reset edge blocks any pending write.
    always_ff @(posedge clk) begin
        if (!reset && access && acc_we && !acc_err) mem[acc_idx] <= wr_word;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign stall_M    = (req_valid && (state_q == IDLE)) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: LATENCY=2 instance for timing/data/error/reset cases,
// LATENCY=0 instance for back-to-back acceptance.
module tb_dmem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, resp_err, stall_M;
    logic [31:0] resp_rdata;

    logic        v0, we0;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        r0_ready, r0_valid, r0_err, stall0;
    logic [31:0] r0_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_resp #(.LATENCY(LAT), .DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall_M(stall_M)
    );

    dmem_resp #(.LATENCY(0), .DEPTH_WORDS(256)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .req_be(be0),
        .req_ready(r0_ready), .resp_valid(r0_valid), .resp_rdata(r0_rdata),
        .resp_err(r0_err), .stall_M(stall0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One request on the LATENCY=2 instance; inputs are scrambled while it waits.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(negedge clk);
        check({tag, ":stall_req"}, stall_M, 1);
        check({tag, ":ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            check({tag, ":rv"}, resp_valid, (k == LAT) ? 1 : 0);
            if (k == 0) check({tag, ":stall_wait"}, stall_M, 1);
            if (k == LAT) begin
                check({tag, ":stall_resp"}, stall_M, 0);
                check({tag, ":err"}, resp_err, exp_err);
            end
            if (chk_rd && k >= LAT) check({tag, ":rdata"}, resp_rdata, exp_rd);
        end
    endtask

    initial begin
        logic [31:0] exp38;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0; be0 = '0;

        @(negedge clk);
        check("rst:rv", resp_valid, 0);
        check("rst:rdata", resp_rdata, 0);
        check("rst:err", resp_err, 0);
        check("rst:ready", req_ready, 1);
        check("rst:stall0", stall_M, 0);
        req_valid = 1'b1; #1;
        check("rst:stall1", stall_M, 1);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
        xact("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0);
        xact("ld11", 1'b0, 32'h11, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);

        xact("st20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0);
        xact("st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h11223344, 1'b0);
`ifdef DMEM_BYTE_WRITE_EN
        exp38 = 32'h11BB33DD;
`else
        exp38 = 32'hAABBCCDD;
`endif
        xact("ld20", 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, exp38, 1'b0);

        xact("st00", 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0);
        xact("ld400", 1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
        xact("st400", 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 1'b1);
        xact("ld00", 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h12345678, 1'b0);

        // Reset pulsed while a store waits: no response, no write.
        xact("st30", 1'b1, 32'h30, 32'h00000077, 4'hF, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstw:stall", stall_M, 1);
        reset = 1'b1; #1;
        check("rstw:rv", resp_valid, 0);
        check("rstw:ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstw:no_resp", resp_valid, 0);
        end
        xact("ld30", 1'b0, 32'h30, 32'h0, 4'hF, 1'b1, 32'h00000077, 1'b0);

        // Zero-latency instance with req_valid held high.
        @(posedge clk); #1;
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h8; wd0 = 32'h000000A5; be0 = 4'hF;
        @(negedge clk);
        check("l0:pre_ready", r0_ready, 1);
        check("l0:pre_rv", r0_valid, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("l0:rv", r0_valid, (k % 2 == 0) ? 1 : 0);
            check("l0:ready", r0_ready, (k % 2 == 0) ? 0 : 1);
            check("l0:stall", stall0, (k % 2 == 0) ? 0 : 1);
            if (k == 2) check("l0:old_rdata", r0_rdata, 32'h000000A5);
        end
        we0 = 1'b0; a0 = 32'h9;
        @(negedge clk);
        check("l0:mis_rv", r0_valid, 1);
        check("l0:mis_err", r0_err, 1);
        check("l0:mis_rdata", r0_rdata, 0);
        v0 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
